// File: rtl/fg_prog_sequencer_if.sv
// Command channel of the floating-gate programming sequencer.
// Handshake: a command transfers on a rising clk edge where valid and ready are both high; fields are only meaningful while valid is high.
interface fg_prog_sequencer_if #(
  parameter int NUM_ISLANDS = 2,
  parameter int NUM_ROWS    = 12,
  parameter int NUM_COLS    = 26,
  parameter int PULSE_W     = 16
);
  localparam int ISL_W = (NUM_ISLANDS > 1) ? $clog2(NUM_ISLANDS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  logic               valid;
  logic               ready;
  logic [1:0]         op;
  logic [ISL_W-1:0]   island;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [PULSE_W-1:0] pulse_len;
  logic [7:0]         pulse_cnt;

  modport master (output valid, op, island, row, col, pulse_len, pulse_cnt, input ready);
  modport slave  (input valid, op, island, row, col, pulse_len, pulse_cnt, output ready);
endinterface

// File: rtl/fg_prog_sequencer.sv
// Floating-gate program/erase pulse sequencer: SETUP -> PULSE/GAP train (or ERASE) -> RELEASE -> IDLE.
// Optional tunnelling erase (op 1) is compiled in when FG_PROG_TUNNEL_EN is defined.
module fg_prog_sequencer #(
  parameter int NUM_ISLANDS = 2,
  parameter int NUM_ROWS    = 12,
  parameter int NUM_COLS    = 26,
  parameter int PULSE_W     = 16,
  parameter int SETTLE      = 4,
  localparam int ISL_W = (NUM_ISLANDS > 1) ? $clog2(NUM_ISLANDS) : 1,
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  fg_prog_sequencer_if.slave     cmd,
  input  logic                   abort,
  output logic [NUM_ISLANDS-1:0] island_en,
  output logic [ROW_W-1:0]       row_sel,
  output logic [COL_W-1:0]       col_sel,
  output logic                   dec_en,
  output logic                   prog_mode,
  output logic                   run_mode,
  output logic                   vinj_pulse,
  output logic                   vtun_en,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             pulses_done,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_GAP     = 3'd3,
`ifdef FG_PROG_TUNNEL_EN
    S_ERASE   = 3'd4,
`endif
    S_RELEASE = 3'd5
  } state_t;

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int CNT_W = (PULSE_W > SET_W) ? PULSE_W : SET_W;
  localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [NUM_ISLANDS-1:0] ISL_ONE     = NUM_ISLANDS'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ISL_W-1:0]   isl_q, isl_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [PULSE_W-1:0] len_q, len_d;
  logic [7:0]         pcnt_q, pcnt_d;
  logic [7:0]         pulses_q, pulses_d;
  logic               aborted_q, aborted_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef FG_PROG_TUNNEL_EN
  logic               erase_q, erase_d;
`endif
  logic               legal;
  logic [CNT_W-1:0]   len_last;
  logic               pulse_more;

  assign len_last   = CNT_W'(len_q - PULSE_W'(1));
  assign pulse_more = (9'(pulses_q) + 9'd1) < 9'(pcnt_q);

  // Command legality is judged on the live bus fields at the accept edge.
  always_comb begin
    legal = 32'(cmd.island) < NUM_ISLANDS;
    case (cmd.op)
      2'd0: begin
        if (32'(cmd.row) >= NUM_ROWS || 32'(cmd.col) >= NUM_COLS ||
            cmd.pulse_len == '0 || cmd.pulse_cnt == '0)
          legal = 1'b0;
      end
`ifdef FG_PROG_TUNNEL_EN
      2'd1: begin
        if (cmd.pulse_len == '0) legal = 1'b0;
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      isl_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      len_q     <= '0;
      pcnt_q    <= '0;
      pulses_q  <= '0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef FG_PROG_TUNNEL_EN
      erase_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isl_q     <= isl_d;
      row_q     <= row_d;
      col_q     <= col_d;
      len_q     <= len_d;
      pcnt_q    <= pcnt_d;
      pulses_q  <= pulses_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef FG_PROG_TUNNEL_EN
      erase_q   <= erase_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isl_d     = isl_q;
    row_d     = row_q;
    col_d     = col_q;
    len_d     = len_q;
    pcnt_d    = pcnt_q;
    pulses_d  = pulses_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef FG_PROG_TUNNEL_EN
    erase_d   = erase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd.valid) begin
          if (legal) begin
            state_d   = S_SETUP;
            cnt_d     = '0;
            isl_d     = cmd.island;
            row_d     = cmd.row;
            col_d     = cmd.col;
            len_d     = cmd.pulse_len;
            pcnt_d    = cmd.pulse_cnt;
            pulses_d  = '0;
            // An abort coinciding with accept is remembered and honoured from SETUP.
            aborted_d = abort;
`ifdef FG_PROG_TUNNEL_EN
            erase_d   = (cmd.op == 2'd1);
            if (cmd.op == 2'd1) begin
              row_d = '0;
              col_d = '0;
            end
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (abort || aborted_q) begin
          state_d   = S_RELEASE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
`ifdef FG_PROG_TUNNEL_EN
          state_d = erase_q ? S_ERASE : S_PULSE;
`else
          state_d = S_PULSE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (abort) begin
          state_d   = S_RELEASE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == len_last) begin
          cnt_d    = '0;
          pulses_d = pulses_q + 8'd1;
          state_d  = pulse_more ? S_GAP : S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_RELEASE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef FG_PROG_TUNNEL_EN
      S_ERASE: begin
        if (abort) begin
          state_d   = S_RELEASE;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == len_last) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_RELEASE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = !aborted_q;
          err_d   = aborted_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drain switches stay in program mode through RELEASE while the decoders are already off.
  always_comb begin
    island_en  = '0;
    row_sel    = '0;
    col_sel    = '0;
    dec_en     = 1'b0;
    prog_mode  = 1'b0;
    run_mode   = 1'b1;
    vinj_pulse = (state_q == S_PULSE);
    if (state_q != S_IDLE) begin
      island_en = ISL_ONE << isl_q;
      row_sel   = row_q;
      col_sel   = col_q;
      dec_en    = (state_q != S_RELEASE);
      prog_mode = 1'b1;
      run_mode  = 1'b0;
    end
  end

`ifdef FG_PROG_TUNNEL_EN
  assign vtun_en = (state_q == S_ERASE);
`else
  assign vtun_en = 1'b0;
`endif

  assign cmd.ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign pulses_done = pulses_q;
  assign state_dbg   = state_q;

endmodule
